// File: rtl/ram_fifo_ctrl.sv
// Circular-buffer controller for the width-converting dual-port RAM.
// Level and pointers are counted in RAM units; push writes WR_IND units and pop frees RD_IND units.
module ram_fifo_ctrl #(
    parameter int RAM_DEPTH      = 64,
    parameter int RAM_ADDR_WIDTH = 6,
    parameter int WR_WIDTH       = 32,
    parameter int RD_WIDTH       = 16,
    parameter int WR_IND         = 4,
    parameter int RD_IND         = 2,
    parameter int AFULL_THR      = 56
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      push,
    input  logic [WR_WIDTH-1:0]       push_data,
    input  logic                      pop,
    output logic [RD_WIDTH-1:0]       pop_data,
    output logic                      pop_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      afull,
    output logic [RAM_ADDR_WIDTH:0]   level,
    output logic                      ovf,
    output logic                      udf,
    output logic                      ram_wr_en,
    output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [WR_WIDTH-1:0]       ram_wr_data,
    output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [RD_WIDTH-1:0]       ram_rd_data
);

    localparam int LW = RAM_ADDR_WIDTH + 1;

    localparam logic [LW-1:0] WR_STEP   = LW'(WR_IND);
    localparam logic [LW-1:0] RD_STEP   = LW'(RD_IND);
    localparam logic [LW-1:0] FULL_LIM  = LW'(RAM_DEPTH - WR_IND);
    localparam logic [LW-1:0] AFULL_LIM = LW'(AFULL_THR);

    localparam logic [RAM_ADDR_WIDTH-1:0] WR_PSTEP = RAM_ADDR_WIDTH'(WR_IND);
    localparam logic [RAM_ADDR_WIDTH-1:0] RD_PSTEP = RAM_ADDR_WIDTH'(RD_IND);

    logic [RAM_ADDR_WIDTH-1:0] wr_ptr;
    logic [RAM_ADDR_WIDTH-1:0] rd_ptr;
    logic [LW-1:0]             level_q;
    logic [LW-1:0]             level_next;
    logic [LW-1:0]             level_seen;
    logic                      push_ok;
    logic                      pop_ok;

    always_comb begin
        push_ok    = push & ~full;
        pop_ok     = pop & ~empty;
        level_next = level_q + (push_ok ? WR_STEP : '0) - (pop_ok ? RD_STEP : '0);
        // Units pushed this cycle are still in flight to the RAM, so empty ignores them for one cycle.
        level_seen = level_next - (push_ok ? WR_STEP : '0);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            afull       <= 1'b0;
            ovf         <= 1'b0;
            udf         <= 1'b0;
            pop_valid   <= 1'b0;
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
        end else begin
            level_q   <= level_next;
            full      <= (level_next > FULL_LIM);
            empty     <= (level_seen < RD_STEP);
            afull     <= (level_next >= AFULL_LIM);
            ovf       <= push & full;
            udf       <= pop & empty;
            pop_valid <= pop_ok;
            ram_wr_en <= push_ok;
            if (push_ok) begin
                ram_wr_addr <= wr_ptr;
                ram_wr_data <= push_data;
                wr_ptr      <= wr_ptr + WR_PSTEP;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + RD_PSTEP;
            end
        end
    end

    assign level       = level_q;
    assign ram_rd_addr = rd_ptr;
    assign pop_data    = ram_rd_data;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural byte-unit RAM (registered read, little-endian units).
// Table of single-cycle vectors followed by fill/drain, steady push+pop and pointer-wrap sequences.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        push = 1'b0;
    logic [31:0] push_data = '0;
    logic        pop = 1'b0;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic        afull;
    logic [6:0]  level;
    logic        ovf;
    logic        udf;
    logic        ram_wr_en;
    logic [5:0]  ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic [5:0]  ram_rd_addr;
    logic [15:0] ram_rd_data = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem [64];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .push        (push),
        .push_data   (push_data),
        .pop         (pop),
        .pop_data    (pop_data),
        .pop_valid   (pop_valid),
        .full        (full),
        .empty       (empty),
        .afull       (afull),
        .level       (level),
        .ovf         (ovf),
        .udf         (udf),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data)
    );

    // RAM model: 8-bit units, 32-bit write port, 16-bit registered read port.
    always @(posedge clk) begin
        logic [5:0] wa;
        logic [5:0] ra;
        ra = ram_rd_addr + 6'd1;
        ram_rd_data <= {mem[ra], mem[ram_rd_addr]};
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                wa = ram_wr_addr + 6'(b);
                mem[wa] <= ram_wr_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic [31:0] d, input logic q, input logic c);
        push      = p;
        push_data = d;
        pop       = q;
        clr       = c;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
        if (p && !full && !c) begin
            exp_q.push_back(d[15:0]);
            exp_q.push_back(d[31:16]);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_pop_sb(input string nm);
        logic [15:0] e;
        chk({nm, "_pv"}, 32'(pop_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({nm, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_data"}, 32'(pop_data), 32'(e));
        end
    endtask

    typedef struct {
        logic        push;
        logic [31:0] data;
        logic        pop;
        logic        clr;
        logic [6:0]  lvl;
        logic        full;
        logic        empty;
        logic        afull;
        logic        ovf;
        logic        udf;
        logic        pv;
        logic [15:0] pdata;
        logic        wen;
        logic [5:0]  waddr;
        logic [5:0]  raddr;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // push, data, pop, clr | level, full, empty, afull, ovf, udf, pop_valid, pop_data, wr_en, wr_addr, rd_addr
        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 7'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 6'd0, 6'd0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 6'd0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 6'd0, 6'd2};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0, 6'd0, 6'd4};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 6'd0, 6'd4};
        tbl[5]  = '{1'b1, 32'h1122_3344, 1'b1, 1'b0, 7'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 6'd4, 6'd4};
        tbl[6]  = '{1'b1, 32'h5566_7788, 1'b1, 1'b0, 7'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 6'd8, 6'd4};
        tbl[7]  = '{1'b1, 32'h9999_9999, 1'b1, 1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 6'd0};
        tbl[8]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 7'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd0, 6'd0};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 7'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0, 6'd0};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 7'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0, 6'd0, 6'd2};

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        do_reset();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full),  32'd0);
        chk("rst_afull", 32'(afull), 32'd0);
        chk("rst_flags", {28'd0, pop_valid, ovf, udf, ram_wr_en}, 32'd0);
        chk("rst_ptrs",  {20'd0, ram_wr_addr, ram_rd_addr}, 32'd0);
        chk("rst_wdata", ram_wr_data, 32'd0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].push, tbl[i].data, tbl[i].pop, tbl[i].clr);
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("vec%0d_flags", i),
                {26'd0, full, empty, afull, ovf, udf, pop_valid},
                {26'd0, tbl[i].full, tbl[i].empty, tbl[i].afull, tbl[i].ovf, tbl[i].udf, tbl[i].pv});
            chk($sformatf("vec%0d_wr", i), {25'd0, ram_wr_en, ram_wr_addr}, {25'd0, tbl[i].wen, tbl[i].waddr});
            chk($sformatf("vec%0d_raddr", i), 32'(ram_rd_addr), 32'(tbl[i].raddr));
            if (tbl[i].pv) chk($sformatf("vec%0d_pdata", i), 32'(pop_data), 32'(tbl[i].pdata));
        end

        // Fill: 16 pushes of data 0..15, then one refused push.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_level", i), 32'(level), 32'(4 * (i + 1)));
            chk($sformatf("fill%0d_waddr", i), 32'(ram_wr_addr), 32'(4 * i));
            chk($sformatf("fill%0d_wdata", i), ram_wr_data, 32'(i));
            chk($sformatf("fill%0d_wen", i), 32'(ram_wr_en), 32'd1);
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
            chk($sformatf("fill%0d_afull", i), 32'(afull), 32'(i >= 13));
            chk($sformatf("fill%0d_empty", i), 32'(empty), 32'(i == 0));
        end
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("fill_ovf", 32'(ovf), 32'd1);
        chk("fill_ovf_level", 32'(level), 32'd64);
        chk("fill_ovf_wen", 32'(ram_wr_en), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("fill_ovf_pulse", 32'(ovf), 32'd0);

        // Drain: 32 pops, then one refused pop.
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("drain%0d_raddr", k), 32'(ram_rd_addr), 32'(2 * k));
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("drain%0d_pv", k), 32'(pop_valid), 32'd1);
            chk($sformatf("drain%0d_pdata", k), 32'(pop_data), (k % 2 == 0) ? 32'(k / 2) : 32'd0);
            chk($sformatf("drain%0d_level", k), 32'(level), 32'(62 - 2 * k));
            chk($sformatf("drain%0d_empty", k), 32'(empty), 32'(k == 31));
            chk($sformatf("drain%0d_full", k), 32'(full), 32'(k == 0));
        end
        chk("drain_raddr_wrap", 32'(ram_rd_addr), 32'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_udf", 32'(udf), 32'd1);
        chk("drain_udf_pv", 32'(pop_valid), 32'd0);
        chk("drain_udf_level", 32'(level), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain_udf_pulse", 32'(udf), 32'd0);

        // Steady push+pop from level 8 until full, then pushes refused while pops continue.
        do_reset();
        step(1'b1, 32'hC000_0000, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0001, 1'b0, 1'b0);
        chk("steady_start_level", 32'(level), 32'd8);
        chk("steady_start_empty", 32'(empty), 32'd0);
        for (int k = 0; k < 27; k++) begin
            step(1'b1, 32'hC000_0002 + 32'(k), 1'b1, 1'b0);
            chk($sformatf("steady%0d_level", k), 32'(level), 32'(10 + 2 * k));
            chk($sformatf("steady%0d_full", k), 32'(full), 32'(k == 26));
            chk($sformatf("steady%0d_afull", k), 32'(afull), 32'(k >= 23));
            chk($sformatf("steady%0d_ovf", k), 32'(ovf), 32'd0);
            chk_pop_sb($sformatf("steady%0d", k));
        end
        step(1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0);
        chk("steady_full_ovf", 32'(ovf), 32'd1);
        chk("steady_full_level", 32'(level), 32'd60);
        chk("steady_full_flag", 32'(full), 32'd0);
        chk_pop_sb("steady_full");

        // Wrap: 20 pushes interleaved with 40 pops, stream order checked.
        do_reset();
        step(1'b1, 32'h7000_0000, 1'b0, 1'b0);
        chk("wrap_w0_addr", 32'(ram_wr_addr), 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        for (int j = 1; j < 20; j++) begin
            step(1'b1, {$urandom_range(65535, 0), 16'(j)}, 1'b1, 1'b0);
            chk($sformatf("wrap%0d_waddr", j), 32'(ram_wr_addr), 32'((4 * j) % 64));
            chk($sformatf("wrap%0d_level_a", j), 32'(level), 32'd6);
            chk_pop_sb($sformatf("wrap%0d_a", j));
            step(1'b0, 32'h0, 1'b1, 1'b0);
            chk($sformatf("wrap%0d_level_b", j), 32'(level), 32'd4);
            chk_pop_sb($sformatf("wrap%0d_b", j));
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_pop_sb("wrap_tail0");
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk_pop_sb("wrap_tail1");
        chk("wrap_end_level", 32'(level), 32'd0);
        chk("wrap_end_empty", 32'(empty), 32'd1);
        chk("wrap_end_raddr", 32'(ram_rd_addr), 32'd16);
        chk("wrap_end_waddr", 32'(ram_wr_addr), 32'd12);
        chk("wrap_end_sb", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
